// File: rtl/gate_arbiter.sv
// Parking gate arbiter: buffers entry/exit requests, picks a winner, issues a
// one-cycle grant and times the door. Define GATE_EXIT_PRIORITY_EN to make exit win ties.
module gate_arbiter #(
    parameter int DOOR_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic [1:0]       exit_req_slot,
    input  logic             is_full,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic [1:0]       grant_slot,
    output logic             door_cmd,
    output logic             entry_pending,
    output logic [CNT_W-1:0] exit_count,
    output logic             entry_drop,
    output logic             exit_drop,
    output logic             busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_OPEN  = 2'd2;
    localparam logic [1:0] S_COOL  = 2'd3;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       TMR_LAST = 4'(DOOR_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       timer_q, timer_d;
    logic             last_ex_q, last_ex_d;
    logic             sel_ex_q, sel_ex_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [1:0]       mem_q [FIFO_DEPTH];

    logic             egnt_q, egnt_d, xgnt_q, xgnt_d;
    logic [1:0]       slot_q, slot_d;
    logic             door_q, door_d, busy_q, busy_d;
    logic             edrop_q, edrop_d, xdrop_q, xdrop_d;

    logic el_en, el_ex, pick_ex, clr, pop, push, full;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        last_ex_d = last_ex_q;
        sel_ex_d  = sel_ex_q;

        el_en = pend_q & ~is_full;
        el_ex = (cnt_q != '0);
`ifdef GATE_EXIT_PRIORITY_EN
        pick_ex = el_ex;
`else
        // Round-robin on a tie: serve the side that did not go last.
        pick_ex = el_ex & (~el_en | ~last_ex_q);
`endif
        clr = (state_q == S_GRANT) & ~sel_ex_q;
        pop = (state_q == S_GRANT) & sel_ex_q;

        case (state_q)
            S_IDLE: begin
                if (el_en | el_ex) begin
                    state_d  = S_GRANT;
                    sel_ex_d = pick_ex;
                end
            end
            S_GRANT: begin
                state_d   = S_OPEN;
                timer_d   = '0;
                last_ex_d = sel_ex_q;
            end
            S_OPEN: begin
                if (timer_q == TMR_LAST) state_d = S_COOL;
                else                     timer_d = timer_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        edrop_d = entry_req & pend_q & ~clr;
        pend_d  = (pend_q & ~clr) | entry_req;

        full    = (cnt_q == FULL_CNT);
        push    = exit_req & (~full | pop);
        xdrop_d = exit_req & full & ~pop;
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop  ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q;
        if (push & ~pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop & ~push) cnt_d = cnt_q - CNT_W'(1);

        // Outputs are registered from the next state so they line up with it.
        egnt_d = (state_d == S_GRANT) & ~sel_ex_d;
        xgnt_d = (state_d == S_GRANT) & sel_ex_d;
        slot_d = xgnt_d ? mem_q[rd_q] : 2'd0;
        door_d = (state_d == S_GRANT) | (state_d == S_OPEN);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            last_ex_q <= 1'b1;
            sel_ex_q  <= 1'b0;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            egnt_q    <= 1'b0;
            xgnt_q    <= 1'b0;
            slot_q    <= 2'd0;
            door_q    <= 1'b0;
            busy_q    <= 1'b0;
            edrop_q   <= 1'b0;
            xdrop_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            last_ex_q <= last_ex_d;
            sel_ex_q  <= sel_ex_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            egnt_q    <= egnt_d;
            xgnt_q    <= xgnt_d;
            slot_q    <= slot_d;
            door_q    <= door_d;
            busy_q    <= busy_d;
            edrop_q   <= edrop_d;
            xdrop_q   <= xdrop_d;
        end
    end

    // Slot storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= exit_req_slot;
    end

    assign entry_grant   = egnt_q;
    assign exit_grant    = xgnt_q;
    assign grant_slot    = slot_q;
    assign door_cmd      = door_q;
    assign entry_pending = pend_q;
    assign exit_count    = cnt_q;
    assign entry_drop    = edrop_q;
    assign exit_drop     = xdrop_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_gate_arbiter.sv
// Bench for gate_arbiter: directed scenarios plus random traffic, checked every
// cycle against a timeline model (grant edge g, door window, request queue).
module tb_gate_arbiter;
    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          entry_req = 1'b0, exit_req = 1'b0, is_full = 1'b0;
    logic [1:0]    exit_req_slot = 2'd0;
    logic          entry_grant, exit_grant, door_cmd, entry_pending;
    logic          entry_drop, exit_drop, busy;
    logic [1:0]    grant_slot;
    logic [CW-1:0] exit_count;

    int n_cmp = 0;
    int n_err = 0;

    gate_arbiter #(.DOOR_CYCLES(D), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
        .exit_req_slot(exit_req_slot), .is_full(is_full),
        .entry_grant(entry_grant), .exit_grant(exit_grant), .grant_slot(grant_slot),
        .door_cmd(door_cmd), .entry_pending(entry_pending), .exit_count(exit_count),
        .entry_drop(entry_drop), .exit_drop(exit_drop), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: edge counter e, grant edge g, winner, pending bit, slot queue.
    int         e = 0;
    int         g = -1000;
    bit         win_ex = 1'b0;
    bit [1:0]   gslot = 2'd0;
    bit         pend = 1'b0;
    bit         last_ex = 1'b1;
    bit [1:0]   q[$];
    bit         x_edrop = 1'b0, x_xdrop = 1'b0;

    function automatic void model_reset();
        g = -1000; win_ex = 1'b0; gslot = 2'd0; pend = 1'b0; last_ex = 1'b1;
        q.delete(); x_edrop = 1'b0; x_xdrop = 1'b0;
    endfunction

    function automatic void model_edge(bit en, bit ex, bit [1:0] sl, bit fl);
        bit clr, pop, el_en, el_ex, pick, qfull;
        e++;
        clr = (e == g + 1) && !win_ex;
        pop = (e == g + 1) && win_ex;
        if (e >= g + D + 3) begin
            el_en = pend && !fl;
            el_ex = (q.size() != 0);
            if (el_en || el_ex) begin
`ifdef GATE_EXIT_PRIORITY_EN
                pick = el_ex;
`else
                pick = el_ex && (!el_en || !last_ex);
`endif
                g = e; win_ex = pick; last_ex = pick;
                gslot = pick ? q[0] : 2'd0;
            end
        end
        x_edrop = en && pend && !clr;
        pend = (pend && !clr) || en;
        qfull = (q.size() == DEPTH);
        x_xdrop = 1'b0;
        if (pop) void'(q.pop_front());
        if (ex) begin
            if (qfull && !pop) x_xdrop = 1'b1;
            else q.push_back(sl);
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, expv);
        end
    endtask

    task automatic check_all();
        bit gnt;
        gnt = (e == g);
        chk("entry_grant",   8'(entry_grant),   8'(gnt && !win_ex));
        chk("exit_grant",    8'(exit_grant),    8'(gnt && win_ex));
        chk("grant_slot",    8'(grant_slot),    (gnt && win_ex) ? 8'(gslot) : 8'd0);
        chk("door_cmd",      8'(door_cmd),      8'(e >= g && e <= g + D));
        chk("busy",          8'(busy),          8'(e >= g && e <= g + D + 1));
        chk("entry_pending", 8'(entry_pending), 8'(pend));
        chk("exit_count",    8'(exit_count),    8'(q.size()));
        chk("entry_drop",    8'(entry_drop),    8'(x_edrop));
        chk("exit_drop",     8'(exit_drop),     8'(x_xdrop));
    endtask

    task automatic step(input bit en, input bit ex, input bit [1:0] sl, input bit fl);
        entry_req = en; exit_req = ex; exit_req_slot = sl; is_full = fl;
        @(posedge clk);
        model_edge(en, ex, sl, fl);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        #1;
        chk("rst_door",  8'(door_cmd),   8'd0);
        chk("rst_busy",  8'(busy),       8'd0);
        chk("rst_count", 8'(exit_count), 8'd0);
        chk("rst_pend",  8'(entry_pending), 8'd0);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;

        // Tie straight out of reset: entry and exit slot 1 together.
        step(1'b1, 1'b1, 2'd1, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);
`ifdef GATE_EXIT_PRIORITY_EN
        chk("tie_exit_first", 8'(exit_grant), 8'd1);
`else
        chk("tie_entry_first", 8'(entry_grant), 8'd1);
`endif
        idle(20);

        // Single entry: grant two edges after the request, door 1+D cycles.
        step(1'b1, 1'b0, 2'd0, 1'b0);
        chk("single_pend", 8'(entry_pending), 8'd1);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        chk("single_grant", 8'(entry_grant), 8'd1);
        idle(10);

        // Entry blocked while full; released once is_full drops.
        step(1'b1, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 2'd0, 1'b1);
        chk("full_still_pend", 8'(entry_pending), 8'd1);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        chk("full_release_grant", 8'(entry_grant), 8'd1);
        idle(10);

        // Exit queue ordering 2, 0, 3.
        step(1'b0, 1'b1, 2'd2, 1'b0);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        step(1'b0, 1'b1, 2'd3, 1'b0);
        idle(30);

        // Entry drop, then exit overflow while the entry is being served.
        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        chk("entry_drop_pulse", 8'(entry_drop), 8'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'(i), 1'b0);
        chk("ovf_count", 8'(exit_count), 8'd4);
        chk("ovf_drop",  8'(exit_drop),  8'd1);
        idle(50);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 20),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 99) < 30));
        idle(60);

        // Reset two cycles into OPEN with exits queued.
        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b0);
        step(1'b0, 1'b1, 2'd3, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_door",  8'(door_cmd),   8'd0);
        chk("rst_mid_busy",  8'(busy),       8'd0);
        chk("rst_mid_count", 8'(exit_count), 8'd0);
        model_reset();
        @(posedge clk); #3;
        reset = 1'b0;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gate_arbiter.md
# gate_arbiter

Shares the single parking-lot gate between the entry sensor and the exit sensor. Entry requests and slot-tagged exit requests are buffered, then the block arbitrates between them. Each winner is serialized into a one-cycle `entry_signal`/`exit_signal`+`exit_slot` command to the parking FSM, and the door is held open for a fixed time. It sits between the sensor inputs and the FSM and owns the door actuator timing.

## Interface
Parameters:
- `DOOR_CYCLES`, default 4: cycles the door stays open after a grant; range 1..15.
- `FIFO_DEPTH`, default 4: exit-request queue depth; power of two, at least 2.
- `CNT_W`, default 3: width of `exit_count`; equals log2(`FIFO_DEPTH`)+1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `entry_req` in 1: one-cycle pulse, car at the entry sensor.
- `exit_req` in 1: one-cycle pulse, car leaving.
- `exit_req_slot` in 2: slot being vacated; valid with `exit_req`.
- `is_full` in 1: from the parking FSM; all 4 spots occupied.
- `entry_grant` out 1: one-cycle command to the FSM `entry_signal`.
- `exit_grant` out 1: one-cycle command to the FSM `exit_signal`.
- `grant_slot` out 2: to the FSM `exit_slot`; valid with `exit_grant`, otherwise 0.
- `door_cmd` out 1: door actuator, 1 = open.
- `entry_pending` out 1: an entry is waiting.
- `exit_count` out CNT_W: exit queue occupancy.
- `entry_drop` out 1: pulse; an entry request was lost.
- `exit_drop` out 1: pulse; an exit request was lost.
- `busy` out 1: state is not IDLE.

## Operation
- Reset value of all outputs is 0. Reset clears the FIFO and `entry_pending`, sets state to IDLE and sets `last_served` to EXIT.
- Entry capture: `entry_req` sets `entry_pending`.
  - If `entry_pending` is already 1 and is not being cleared this cycle, the new request is dropped and `entry_drop` pulses.
- Exit capture: `exit_req` pushes `exit_req_slot` into the FIFO.
  - If the FIFO is full and not popping this cycle, the request is dropped and `exit_drop` pulses.
  - A push and a pop in the same cycle is legal; the count is unchanged.
- Eligibility:
  - Entry is eligible when `entry_pending` is 1 and `is_full` is 0.
  - Exit is eligible when `exit_count` is nonzero.
  - `is_full` is sampled only in IDLE. An entry blocked by `is_full` stays pending, without timeout.
- Arbitration in IDLE:
  - If only one side is eligible, it wins.
  - If both are eligible, the winner is the side opposite `last_served` (round-robin). After reset, entry wins the first tie.
- States:
  - IDLE: go to GRANT if any side is eligible, otherwise stay.
  - GRANT (1 cycle): `door_cmd` = 1. Pulse `entry_grant`, or pulse `exit_grant` with `grant_slot` = FIFO head. Clear `entry_pending` or pop the FIFO. Update `last_served`. Go to OPEN.
  - OPEN: `door_cmd` = 1. The 4-bit timer counts DOOR_CYCLES cycles, then go to COOLDOWN.
  - COOLDOWN (1 cycle): `door_cmd` = 0. Go to IDLE.
- Requests arriving in any state are captured. Only IDLE launches a grant.
- Reset mid-service: `door_cmd` drops immediately (asynchronously) and the in-flight grant is abandoned.

## Timing
- All outputs are registered (Moore); there are no combinational input-to-output paths.
- Request latency: a request sampled at edge k is visible in `entry_pending`/`exit_count` after edge k. The grant is asserted for the cycle after edge k+1, assuming the block was IDLE and the request wins.
- Door timing: `door_cmd` is high for exactly 1+DOOR_CYCLES cycles per service.
- Back-to-back grants are spaced DOOR_CYCLES+3 cycles apart: GRANT, OPEN×D, COOLDOWN, IDLE.
- `entry_drop` and `exit_drop` assert in the cycle after the offending request edge.

## Configuration
- `GATE_EXIT_PRIORITY_EN`:
  - Defined: exit always wins a tie and `last_served` is ignored, so spots are freed before cars are admitted.
  - Undefined: round-robin as in Operation.

## Test plan
- Single entry, `is_full`=0, DOOR_CYCLES=4: `entry_req` pulse → `entry_grant` one cycle 2 edges later; `door_cmd` high 5 cycles; `busy` low after 7 cycles.
- Entry while full: `is_full`=1, `entry_req` → `entry_pending`=1 and no grant for 20 cycles. Drop `is_full` → `entry_grant` follows 1 cycle later, with `entry_pending` clearing.
- Exit queue order: exits for slots 2, 0, 3 on consecutive cycles → `exit_count` reaches 3; grants come out with `grant_slot` 2, 0, 3, spaced 7 cycles apart.
- Overflow: 5 `exit_req` with no service possible (busy serving a long entry) → `exit_count`=4 and one `exit_drop` pulse. A second `entry_req` while one is pending → `entry_drop` pulse.
- Tie after reset: `entry_req` and `exit_req` (slot 1) in the same cycle → entry granted first, then exit slot 1. With `GATE_EXIT_PRIORITY_EN` defined → exit first.
- Reset in OPEN: assert `reset` 2 cycles into OPEN → `door_cmd`, `busy` and `exit_count` go to 0 immediately; no grant follows after release.
